// File: rtl/ultra_pkg.sv
// Shared state encoding, default sensor timing and width helpers for the ultrasonic ranger.
package ultra_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE
    } ultra_state_t;

    // Defaults assume a 50 MHz clock and an HC-SR04 style sensor.
    localparam int DIST_W_DEF      = 16;
    localparam int TRIG_CYC_DEF    = 500;
    localparam int CYC_PER_CM_DEF  = 2900;
    localparam int MAX_CM_DEF      = 400;
    localparam int ECHO_TO_CYC_DEF = 1500000;
    localparam int HOLDOFF_CYC_DEF = 3000000;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [63:0] out_of_range(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    localparam logic [DIST_W_DEF-1:0] OUT_OF_RANGE = DIST_W_DEF'(out_of_range(DIST_W_DEF));

endpackage

// File: rtl/ultra_median3.sv
// Running median of the current result and the two before it; the first result after reset
// fills the whole window. Output is registered, adding one cycle to the strobe.
module ultra_median3
    import ultra_pkg::*;
#(
    parameter int DIST_W = DIST_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DIST_W-1:0] in_data,
    output logic              out_vld,
    output logic [DIST_W-1:0] out_data
);

    logic              filled;
    logic [DIST_W-1:0] hist_a;
    logic [DIST_W-1:0] hist_b;
    logic [DIST_W-1:0] win_b;
    logic [DIST_W-1:0] win_c;
    logic [DIST_W-1:0] med_p0;
    logic [DIST_W-1:0] dist_p1;
    logic              vld_p1;

    function automatic logic [DIST_W-1:0] median3(
        input logic [DIST_W-1:0] a,
        input logic [DIST_W-1:0] b,
        input logic [DIST_W-1:0] c
    );
        if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
        if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
        return c;
    endfunction

    always_comb begin
        win_b  = filled ? hist_a : in_data;
        win_c  = filled ? hist_b : in_data;
        med_p0 = median3(in_data, win_b, win_c);
    end

    // p0 -> p1: history shift and registered median
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled  <= 1'b0;
            hist_a  <= '0;
            hist_b  <= '0;
            dist_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_vld;
            if (in_vld) begin
                filled  <= 1'b1;
                hist_a  <= in_data;
                hist_b  <= win_b;
                dist_p1 <= med_p0;
            end
        end
    end

    assign out_vld  = vld_p1;
    assign out_data = dist_p1;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 front-end: TRIG pulse, echo timing, cm conversion, timeout and re-trigger holdoff.
// Define ULTRA_MEDIAN_EN to report the median of the last three results (one extra cycle).
module ultrasonic_ranger
    import ultra_pkg::*;
#(
    parameter int DIST_W      = DIST_W_DEF,
    parameter int TRIG_CYC    = TRIG_CYC_DEF,
    parameter int CYC_PER_CM  = CYC_PER_CM_DEF,
    parameter int MAX_CM      = MAX_CM_DEF,
    parameter int ECHO_TO_CYC = ECHO_TO_CYC_DEF,
    parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic              echo,
    output logic              trig_out,
    output logic              triggerSuc,
    output logic              valid,
    output logic [DIST_W-1:0] distance
);

    localparam int TRIG_W = cnt_w(TRIG_CYC);
    localparam int TO_W   = cnt_w(ECHO_TO_CYC);
    localparam int PRE_W  = cnt_w(CYC_PER_CM);
    localparam int CM_W   = cnt_w(MAX_CM + 1);
    localparam int HO_W   = cnt_w(HOLDOFF_CYC);
    localparam logic [DIST_W-1:0] OOR = DIST_W'(out_of_range(DIST_W));

    ultra_state_t      state;
    ultra_state_t      state_nxt;
    logic [TRIG_W-1:0] trig_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [PRE_W-1:0]  pre_cnt;
    logic [CM_W-1:0]   cm_cnt;
    logic [CM_W-1:0]   cm_nxt;
    logic [HO_W-1:0]   holdoff_cnt;
    logic              echo_s1;
    logic              echo_s2;
    logic              echo_prev;
    logic              echo_rise;
    logic              echo_fall;
    logic              pre_wrap;
    logic              cm_hit;
    logic              trig_last;
    logic              to_last;
    logic              finish;
    logic [DIST_W-1:0] result;
    logic [DIST_W-1:0] dist_p0;
    logic              vld_p0;

    function automatic logic [CM_W-1:0] cm_sat_inc(input logic [CM_W-1:0] v);
        return (v == CM_W'(MAX_CM)) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s1   <= 1'b0;
            echo_s2   <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_s1   <= echo;
            echo_s2   <= echo_s1;
            echo_prev <= echo_s2;
        end
    end

    assign echo_rise = echo_s2 & ~echo_prev;
    assign echo_fall = ~echo_s2 & echo_prev;
    assign pre_wrap  = (pre_cnt == PRE_W'(CYC_PER_CM - 1));
    assign cm_nxt    = pre_wrap ? cm_sat_inc(cm_cnt) : cm_cnt;
    assign cm_hit    = (cm_nxt == CM_W'(MAX_CM));
    assign trig_last = (trig_cnt == TRIG_W'(TRIG_CYC - 1));
    assign to_last   = (to_cnt == TO_W'(ECHO_TO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The cycle that ends a measurement counts toward the cm total, so an echo of exactly
    // N*CYC_PER_CM cycles reports N; a MAX_CM hit wins over a coincident falling edge.
    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        result    = OOR;
        unique case (state)
            IDLE: begin
                if (trigger && holdoff_cnt == '0) state_nxt = TRIG;
            end
            TRIG: begin
                if (trig_last) state_nxt = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_nxt = MEASURE;
                end else if (to_last) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            MEASURE: begin
                if (cm_hit || echo_fall) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                    if (!cm_hit) result = DIST_W'(cm_nxt);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // p0: counters, TRIG pin and the raw result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cnt    <= '0;
            to_cnt      <= '0;
            pre_cnt     <= '0;
            cm_cnt      <= '0;
            holdoff_cnt <= '0;
            trig_out    <= 1'b0;
            triggerSuc  <= 1'b0;
            dist_p0     <= '0;
            vld_p0      <= 1'b0;
        end else begin
            triggerSuc <= 1'b0;
            vld_p0     <= finish;
            if (finish) dist_p0 <= result;
            unique case (state)
                IDLE: begin
                    if (holdoff_cnt != '0) begin
                        holdoff_cnt <= holdoff_cnt - 1'b1;
                    end else if (trigger) begin
                        trig_cnt <= '0;
                        trig_out <= 1'b1;
                    end
                end
                TRIG: begin
                    if (trig_last) begin
                        trig_out   <= 1'b0;
                        triggerSuc <= 1'b1;
                        to_cnt     <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    if (echo_rise) begin
                        pre_cnt <= '0;
                        cm_cnt  <= '0;
                    end else if (!to_last) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
                    cm_cnt  <= cm_nxt;
                end
                DONE: begin
                    holdoff_cnt <= HO_W'(HOLDOFF_CYC - 1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ULTRA_MEDIAN_EN
    ultra_median3 #(
        .DIST_W(DIST_W)
    ) u_median (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (vld_p0),
        .in_data (dist_p0),
        .out_vld (valid),
        .out_data(distance)
    );
`else
    assign valid    = vld_p0;
    assign distance = dist_p0;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with shortened timing parameters.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

    localparam int DIST_W      = 16;
    localparam int TRIG_CYC    = 5;
    localparam int CYC_PER_CM  = 2;
    localparam int MAX_CM      = 60;
    localparam int ECHO_TO_CYC = 60;
    localparam int HOLDOFF_CYC = 30;
    localparam int BUDGET      = 400;
`ifdef ULTRA_MEDIAN_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam logic [DIST_W-1:0] OOR = {DIST_W{1'b1}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trigger = 1'b0;
    logic              echo = 1'b0;
    logic              trig_out;
    logic              triggerSuc;
    logic              valid;
    logic [DIST_W-1:0] distance;

    int total = 0;
    int bad   = 0;

`ifdef ULTRA_MEDIAN_EN
    logic              m_filled = 1'b0;
    logic [DIST_W-1:0] m_a = '0;
    logic [DIST_W-1:0] m_b = '0;
`endif

    always #5 clk = ~clk;

    ultrasonic_ranger #(
        .DIST_W     (DIST_W),
        .TRIG_CYC   (TRIG_CYC),
        .CYC_PER_CM (CYC_PER_CM),
        .MAX_CM     (MAX_CM),
        .ECHO_TO_CYC(ECHO_TO_CYC),
        .HOLDOFF_CYC(HOLDOFF_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .echo      (echo),
        .trig_out  (trig_out),
        .triggerSuc(triggerSuc),
        .valid     (valid),
        .distance  (distance)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DIST_W-1:0] med3(input logic [DIST_W-1:0] a,
                                               input logic [DIST_W-1:0] b,
                                               input logic [DIST_W-1:0] c);
        logic [DIST_W-1:0] lo, hi, m;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m  = (hi < c) ? hi : c;
        return (lo > m) ? lo : m;
    endfunction

    task automatic expect_dist(input logic [DIST_W-1:0] raw, output logic [DIST_W-1:0] e);
`ifdef ULTRA_MEDIAN_EN
        if (!m_filled) begin
            m_a = raw;
            m_b = raw;
            m_filled = 1'b1;
        end
        e   = med3(raw, m_a, m_b);
        m_b = m_a;
        m_a = raw;
`else
        e = raw;
`endif
    endtask

    task automatic model_reset();
`ifdef ULTRA_MEDIAN_EN
        m_filled = 1'b0;
`endif
    endtask

    // Raise trigger, time the TRIG pulse and the triggerSuc strobe. exp_rise < 0 only bounds the wait.
    task automatic fire(input string tag, input int drop_at, input bit keep, input int exp_rise);
        int n, hi;
        logic suc_early;
        trigger = 1'b1;
        n = 0;
        while (trig_out !== 1'b1 && n < BUDGET) begin
            tick(1);
            n++;
        end
        if (exp_rise >= 0) chk({tag, "_rise"}, 32'(n), 32'(exp_rise));
        else               chk({tag, "_rise_bound"}, 32'(n < BUDGET), 32'd1);
        hi = 0;
        suc_early = 1'b0;
        while (trig_out === 1'b1 && hi < BUDGET) begin
            if (triggerSuc !== 1'b0) suc_early = 1'b1;
            tick(1);
            hi++;
            if (hi == drop_at) trigger = 1'b0;
        end
        chk({tag, "_width"}, 32'(hi), 32'(TRIG_CYC));
        chk({tag, "_suc_early"}, 32'(suc_early), 32'd0);
        chk({tag, "_suc"}, 32'(triggerSuc), 32'd1);
        if (!keep) trigger = 1'b0;
        tick(1);
        chk({tag, "_suc_once"}, 32'(triggerSuc), 32'd0);
    endtask

    // Echo high for exactly w cycles; expected cm = floor(w / CYC_PER_CM).
    task automatic pulse(input string tag, input int w, input logic [DIST_W-1:0] raw);
        int n;
        logic [DIST_W-1:0] e;
        tick(2);
        echo = 1'b1;
        tick(w);
        echo = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < BUDGET) begin
            tick(1);
            n++;
        end
        expect_dist(raw, e);
        chk({tag, "_lat"}, 32'(n), 32'(LAT));
        chk({tag, "_dist"}, 32'(distance), 32'(e));
        chk({tag, "_excl"}, 32'(triggerSuc), 32'd0);
        tick(1);
        chk({tag, "_one_shot"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int n, cnt;
        logic [DIST_W-1:0] e;

        tick(3);
        chk("rst_trig_out", 32'(trig_out), 32'd0);
        chk("rst_suc", 32'(triggerSuc), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_dist", 32'(distance), 32'd0);
        rst_n = 1'b1;

        fire("t1", 0, 1'b0, 1);
        pulse("cm6", 12, 16'd6);

        fire("t2_drop", 2, 1'b0, -1);
        pulse("trunc", 13, 16'd6);

        fire("t3", 0, 1'b0, -1);
        pulse("cm59", 119, 16'd59);

        fire("t4", 0, 1'b0, -1);
        pulse("max_sim", 120, OOR);

        // No echo: WAIT_ECHO was entered on the triggerSuc edge, one cycle before now.
        fire("t5", 0, 1'b0, -1);
        n = 0;
        while (valid !== 1'b1 && n < BUDGET) begin
            tick(1);
            n++;
        end
        expect_dist(OOR, e);
        chk("timeout_lat", 32'(n), 32'(ECHO_TO_CYC + LAT - 4));
        chk("timeout_dist", 32'(distance), 32'(e));
        tick(1);
        chk("timeout_one_shot", 32'(valid), 32'd0);

        // Echo held high for 150 cycles: MAX_CM is reached at 120 while echo is still high.
        fire("t6", 0, 1'b0, -1);
        tick(2);
        echo = 1'b1;
        n = 0;
        while (valid !== 1'b1 && n < BUDGET) begin
            tick(1);
            n++;
        end
        expect_dist(OOR, e);
        chk("long_lat", 32'(n), 32'(MAX_CM * CYC_PER_CM + LAT));
        chk("long_dist", 32'(distance), 32'(e));
        tick(1);
        chk("long_one_shot", 32'(valid), 32'd0);
        tick(150 - (n + 1));
        echo = 1'b0;
        cnt = 0;
        repeat (20) begin
            tick(1);
            if (valid === 1'b1) cnt++;
        end
        chk("long_no_second", 32'(cnt), 32'd0);
        chk("long_hold", 32'(distance), 32'(e));

        // Trigger held across valid: next TRIG waits out the holdoff.
        fire("t7_keep", 0, 1'b1, -1);
        pulse("cm10", 20, 16'd10);
        fire("t8_holdoff", 0, 1'b0, HOLDOFF_CYC + 3 - LAT);

        // Asynchronous reset during MEASURE.
        tick(2);
        echo = 1'b1;
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("mrst_trig_out", 32'(trig_out), 32'd0);
        chk("mrst_suc", 32'(triggerSuc), 32'd0);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_dist", 32'(distance), 32'd0);
        echo = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        fire("post_rst", 0, 1'b0, 1);
        pulse("seq10", 20, 16'd10);
        fire("t9", 0, 1'b0, -1);
        pulse("seq50", 100, 16'd50);
        fire("t10", 0, 1'b0, -1);
        pulse("seq12", 24, 16'd12);

        // Asynchronous reset while the TRIG pin is high.
        trigger = 1'b1;
        n = 0;
        while (trig_out !== 1'b1 && n < BUDGET) begin
            tick(1);
            n++;
        end
        chk("trst_rise_bound", 32'(n < BUDGET), 32'd1);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("trst_trig_out", 32'(trig_out), 32'd0);
        chk("trst_dist", 32'(distance), 32'd0);
        trigger = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
